// File: rtl/overlap_pkg.sv
// overlap_pkg
// Shared definitions for the overlap-add stage: default sizing, the
// FIRST/SECOND half-frame state type and the saturating adder used to form
// each PCM sample.
// Ports: none (package).
package overlap_pkg;

  localparam int DEFAULT_HALF_WIN = 512;
  localparam int DEFAULT_WORD_LEN = 16;
  localparam int IDX_W            = $clog2(2 * DEFAULT_HALF_WIN);

  // Container width for sat_add; any WORD_LEN up to this width is supported.
  localparam int SAT_W = 32;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } oa_state_t;

  // Adds two sign-extended word_len-bit operands in SAT_W+1 bits and clamps
  // the result to the signed word_len range. The caller keeps the low
  // word_len bits of the returned value.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      word_len
  );
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi  = $signed(((SAT_W+1)'(1) << (word_len - 1)) - (SAT_W+1)'(1));
    lo  = -hi - $signed((SAT_W+1)'(1));
    if (sum > hi) begin
      sat_add = hi[SAT_W-1:0];
    end else if (sum < lo) begin
      sat_add = lo[SAT_W-1:0];
    end else begin
      sat_add = sum[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/overlap_buffer.sv
// overlap_buffer
// Holds the second half of the previous frame until the next frame's first
// half arrives. Register array with one synchronous write port and one
// combinational read port; contents are deliberately not reset.
// Ports:
//   clk   - system clock
//   we    - write enable
//   waddr - write address (0..HALF_WIN-1)
//   wdata - sample to store
//   raddr - read address (0..HALF_WIN-1)
//   rdata - stored sample at raddr (combinational)
module overlap_buffer
  import overlap_pkg::*;
#(
  parameter int HALF_WIN = DEFAULT_HALF_WIN,
  parameter int WORD_LEN = DEFAULT_WORD_LEN
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(HALF_WIN)-1:0] waddr,
  input  logic [WORD_LEN-1:0]         wdata,
  input  logic [$clog2(HALF_WIN)-1:0] raddr,
  output logic [WORD_LEN-1:0]         rdata
);

  logic [WORD_LEN-1:0] mem [HALF_WIN];

  // Storage write; no reset because the primed flag masks stale contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/overlap_add.sv
// overlap_add
// Streaming overlap-add stage. For each frame of 2*HALF_WIN windowed samples,
// first-half samples are added (with saturation) to the stored second half of
// the previous frame and emitted as PCM; second-half samples are stored for
// the next frame and produce no output.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   in_valid/in_ready  - input handshake; in_data is the windowed sample
//   out_valid/out_ready- output handshake; out_data is the saturated PCM sample
//   frame_done         - pulses in the cycle the last sample of a frame is accepted
//   primed             - high once a full frame has been accepted since reset
module overlap_add
  import overlap_pkg::*;
#(
  parameter int HALF_WIN = DEFAULT_HALF_WIN,
  parameter int WORD_LEN = DEFAULT_WORD_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_LEN-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_data,
  output logic                frame_done,
  output logic                primed
);

  localparam int ADDR_W = $clog2(HALF_WIN);
  localparam int CNT_W  = $clog2(2 * HALF_WIN);
  localparam logic [CNT_W-1:0] LAST_FIRST_IDX = CNT_W'(HALF_WIN - 1);
  localparam logic [CNT_W-1:0] LAST_IDX       = CNT_W'(2 * HALF_WIN - 1);

  oa_state_t           state;
  oa_state_t           state_next;
  logic [CNT_W-1:0]    idx;
  logic                accept;
  logic                out_load;
  logic                buf_we;
  logic [WORD_LEN-1:0] buf_rdata;
  logic [ADDR_W-1:0]   buf_addr;
  logic signed [SAT_W-1:0] in_ext;
  logic signed [SAT_W-1:0] buf_ext;
  logic signed [SAT_W-1:0] sum_full;
  logic [WORD_LEN-1:0] sum;

  // HALF_WIN is a power of two, so the low bits of idx are idx-HALF_WIN in
  // SECOND and idx itself in FIRST; one address serves both ports.
  assign buf_addr = idx[ADDR_W-1:0];

  overlap_buffer #(
    .HALF_WIN (HALF_WIN),
    .WORD_LEN (WORD_LEN)
  ) u_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (in_data),
    .raddr (buf_addr),
    .rdata (buf_rdata)
  );

  // Before the first full frame the buffer holds garbage, so its term is zero.
  always_comb begin
    in_ext   = SAT_W'($signed(in_data));
    buf_ext  = primed ? SAT_W'($signed(buf_rdata)) : '0;
    sum_full = sat_add(in_ext, buf_ext, WORD_LEN);
    sum      = sum_full[WORD_LEN-1:0];
  end

  // Handshake and next-state logic. FIRST is gated by the one-deep output
  // register; SECOND never produces output so it always accepts.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    out_load   = 1'b0;
    buf_we     = 1'b0;
    frame_done = 1'b0;
    case (state)
      FIRST:   in_ready = !out_valid || out_ready;
      SECOND:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    if (rst) begin
      in_ready = 1'b0;
    end
    accept   = in_valid && in_ready;
    out_load = accept && (state == FIRST);
    buf_we   = accept && (state == SECOND);
    if (out_load && (idx == LAST_FIRST_IDX)) begin
      state_next = SECOND;
    end
    if (buf_we && (idx == LAST_IDX)) begin
      frame_done = 1'b1;
      state_next = FIRST;
    end
  end

  // State, sample counter, primed flag and the output skid register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FIRST;
      idx       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        idx <= idx + CNT_W'(1);
      end
      if (frame_done) begin
        primed <= 1'b1;
      end
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= sum;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
